regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the register file's single write port (wEn/rd/write_data).
- Arbitrates that port between two writeback requesters: req 0 = ALU, req 1 = load/store unit, each with a valid/ready handshake.
- Keeps a per-register pending-write scoreboard. Issue logic uses it for RAW/WAW hazard checks.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width of write_data and requester data.
- NREG, 32, number of architectural registers; x0 is hardwired zero.
- AW, 5, register index width; AW = log2(NREG).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  issue stage declares a new producer of iss_rd
- iss_rd  in  AW  destination of the issuing instruction
- iss_ready  out  1  issue may proceed (no WAW conflict)
- rs1_q  in  AW  hazard query index 1
- rs2_q  in  AW  hazard query index 2
- rs1_busy  out  1  rs1_q has a pending write
- rs2_busy  out  1  rs2_q has a pending write
- alu_valid  in  1  ALU result available
- alu_rd  in  AW  ALU destination
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- lsu_valid  in  1  load result available
- lsu_rd  in  AW  load destination
- lsu_data  in  XLEN  load result
- lsu_ready  out  1  load result accepted this cycle
- wEn  out  1  regfile write enable (registered)
- rd  out  AW  regfile write index (registered)
- write_data  out  XLEN  regfile write data (registered)
- grant_cnt  out  16  total accepted writebacks, saturating

Behaviour:
- Reset, asynchronous on rst_n low:
  - wEn=0, rd=0, write_data=0, grant_cnt=0.
  - All pending bits cleared.
  - last_grant=1, so the ALU wins the first tie.
- Handshake:
  - At most one of alu_ready/lsu_ready is high per cycle.
  - A transfer occurs when valid && ready are high at a rising edge.
  - A requester must hold valid, rd and data stable until accepted.
- Arbitration, combinational each cycle:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester other than last_grant.
  - last_grant updates only on a transfer.
  - Neither valid: no grant, last_grant holds.
- Write latency = 1:
  - A transfer at edge N drives wEn=1, rd, write_data for the cycle after edge N.
  - The regfile commits at edge N+1.
  - wEn=0 in every cycle with no preceding transfer.
- x0:
  - A transfer with rd=0 is accepted (ready asserted) and counted in grant_cnt.
  - The registered wEn stays 0 for that transfer.
  - pending[0] is never set.
- Scoreboard:
  - pending[r] is set at an edge where iss_valid && iss_ready && iss_rd=r && r!=0.
  - pending[r] is cleared at the edge of a transfer with rd=r.
  - Simultaneous set and clear of the same r: set wins (new producer).
- iss_ready = !pending[iss_rd] || (transfer with rd==iss_rd this cycle). iss_rd=0 is always ready.
- Busy queries:
  - rsX_busy = pending[rsX_q], combinational.
  - Forced 0 for index 0.
  - Forced 0 when a transfer to that index occurs this cycle. The value lands one cycle later, so the consumer must not read before then.
- A transfer whose rd has no pending bit is legal (e.g. after a flush). It writes the regfile; the scoreboard is unchanged.
- grant_cnt increments on every transfer and saturates at 16'hFFFF.
- Reset mid-operation:
  - An in-flight registered write is dropped (wEn forced 0 asynchronously).
  - The scoreboard is cleared.
  - Requesters re-present after reset.

Optional Feature:
- Macro: WB_ARB_FIXED_PRIO_EN.
- Defined: the LSU always wins ties and last_grant is unused. Load latency is minimised; ALU starvation is allowed by design.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package/header:
  - XLEN, NREG, AW constants.
  - Requester index constants REQ_ALU=0, REQ_LSU=1.
  - Grant encoding typedef.
- One natural sub-module, wb_scoreboard: the pending bit vector, set/clear logic, and the iss_ready/busy lookups.
- Arbiter, output register and counter stay in the top.

Test Plan:
- Reset: hold rst_n=0 mid-cycle with a prior transfer in flight -> wEn=0, grant_cnt=0, rs1_busy=0 for every index immediately.
- Single ALU write, alu_rd=5, alu_data=32'h55555555:
  - alu_ready=1 the same cycle.
  - Next cycle: wEn=1, rd=5, write_data=32'h55555555.
  - Following cycle: wEn=0.
- Tie sequence, alu and lsu both valid for 4 cycles (distinct rd 1..4) -> grants in order ALU, LSU, ALU, LSU. With WB_ARB_FIXED_PRIO_EN: LSU, LSU, ...
- Scoreboard:
  - Issue iss_rd=7 -> rs1_q=7 gives rs1_busy=1.
  - Second issue to 7 -> iss_ready=0.
  - LSU transfer to rd 7 -> iss_ready=1 that cycle and busy=0.
- Set/clear same cycle: ALU transfer rd=9 while issuing iss_rd=9 -> pending[9]=1 afterwards.
- x0: LSU transfer with rd=0 and data 32'hDEADBEEF -> lsu_ready=1, grant_cnt+1, wEn remains 0; issue iss_rd=0 -> never busy.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// The WB_ARB_FIXED_PRIO_EN build option is described in regfile_wb_arbiter.sv.
package regfile_wb_arbiter_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);

   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_LSU = 1'b1;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_ALU  = 2'd1,
      GNT_LSU  = 2'd2
   } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of issue, hazard-query, writeback-requester and regfile-write signals.
// Handshake: a transfer happens at a rising edge where valid && ready; the
// requester holds valid/rd/data stable until accepted, and ready is combinational.
interface regfile_wb_arbiter_if;
   import regfile_wb_arbiter_pkg::*;

   logic            iss_valid;
   logic [AW-1:0]   iss_rd;
   logic            iss_ready;
   logic [AW-1:0]   rs1_q;
   logic [AW-1:0]   rs2_q;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            alu_valid;
   logic [AW-1:0]   alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;
   logic            lsu_valid;
   logic [AW-1:0]   lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            lsu_ready;
   logic            wEn;
   logic [AW-1:0]   rd;
   logic [XLEN-1:0] write_data;
   logic [15:0]     grant_cnt;

   modport slave (
      input  iss_valid, iss_rd, rs1_q, rs2_q,
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      output iss_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready,
      output wEn, rd, write_data, grant_cnt
   );

   modport master (
      output iss_valid, iss_rd, rs1_q, rs2_q,
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
      input  iss_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready,
      input  wEn, rd, write_data, grant_cnt
   );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared by the writeback transfer; drives WAW stall and RAW busy lookups.
module wb_scoreboard
   import regfile_wb_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_rd,
   input  logic          xfer,
   input  logic [AW-1:0] xfer_rd,
   input  logic [AW-1:0] rs1_q,
   input  logic [AW-1:0] rs2_q,
   output logic          iss_ready,
   output logic          rs1_busy,
   output logic          rs2_busy
);

   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_nxt;

   always_comb begin
      iss_ready = (iss_rd == '0) || !pending[iss_rd] || (xfer && (xfer_rd == iss_rd));
      rs1_busy  = (rs1_q != '0) && pending[rs1_q] && !(xfer && (xfer_rd == rs1_q));
      rs2_busy  = (rs2_q != '0) && pending[rs2_q] && !(xfer && (xfer_rd == rs2_q));
   end

   // Clear first, then set, so a new producer issued in the same cycle survives.
   always_comb begin
      pending_nxt = pending;
      if (xfer)
         pending_nxt[xfer_rd] = 1'b0;
      if (iss_valid && iss_ready && (iss_rd != '0))
         pending_nxt[iss_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between ALU and LSU writeback, with scoreboard.
// Build option WB_ARB_FIXED_PRIO_EN: LSU always wins ties instead of round-robin.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   regfile_wb_arbiter_if.slave bus
);

   grant_e          grant;
   logic            xfer;
   logic [AW-1:0]   xfer_rd;
   logic [XLEN-1:0] xfer_data;

`ifndef WB_ARB_FIXED_PRIO_EN
   logic last_grant;
`endif

   always_comb begin
      grant = GNT_NONE;
      if (bus.alu_valid && bus.lsu_valid) begin
`ifdef WB_ARB_FIXED_PRIO_EN
         grant = GNT_LSU;
`else
         grant = (last_grant == REQ_LSU) ? GNT_ALU : GNT_LSU;
`endif
      end else if (bus.alu_valid) begin
         grant = GNT_ALU;
      end else if (bus.lsu_valid) begin
         grant = GNT_LSU;
      end
   end

   always_comb begin
      bus.alu_ready = (grant == GNT_ALU);
      bus.lsu_ready = (grant == GNT_LSU);
      xfer          = (grant != GNT_NONE);
      xfer_rd       = (grant == GNT_LSU) ? bus.lsu_rd   : bus.alu_rd;
      xfer_data     = (grant == GNT_LSU) ? bus.lsu_data : bus.alu_data;
   end

`ifndef WB_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= REQ_LSU;
      else if (xfer)
         last_grant <= (grant == GNT_LSU) ? REQ_LSU : REQ_ALU;
   end
`endif

   // Writes to x0 are accepted and counted but never reach the regfile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.wEn        <= 1'b0;
         bus.rd         <= '0;
         bus.write_data <= '0;
      end else begin
         bus.wEn <= xfer && (xfer_rd != '0);
         if (xfer) begin
            bus.rd         <= xfer_rd;
            bus.write_data <= xfer_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bus.grant_cnt <= '0;
      else if (xfer && (bus.grant_cnt != 16'hFFFF))
         bus.grant_cnt <= bus.grant_cnt + 16'd1;
   end

   wb_scoreboard u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (bus.iss_valid),
      .iss_rd    (bus.iss_rd),
      .xfer      (xfer),
      .xfer_rd   (xfer_rd),
      .rs1_q     (bus.rs1_q),
      .rs2_q     (bus.rs2_q),
      .iss_ready (bus.iss_ready),
      .rs1_busy  (bus.rs1_busy),
      .rs2_busy  (bus.rs2_busy)
   );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus hand-written
// sequences for ties, mid-operation reset and the first tie after reset.
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errs;
   int   exp_cnt;

   regfile_wb_arbiter_if bus();

   regfile_wb_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic            iv;
      logic [AW-1:0]   ird;
      logic [AW-1:0]   q1;
      logic [AW-1:0]   q2;
      logic            av;
      logic [AW-1:0]   ard;
      logic [XLEN-1:0] ad;
      logic            lv;
      logic [AW-1:0]   lrd;
      logic [XLEN-1:0] ld;
      logic            ar;
      logic            lr;
      logic            ir;
      logic            b1;
      logic            b2;
      logic            wen;
      logic [AW-1:0]   wrd;
      logic [XLEN-1:0] wd;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.iss_valid = 1'b0;
      bus.iss_rd    = '0;
      bus.rs1_q     = '0;
      bus.rs2_q     = '0;
      bus.alu_valid = 1'b0;
      bus.alu_rd    = '0;
      bus.alu_data  = '0;
      bus.lsu_valid = 1'b0;
      bus.lsu_rd    = '0;
      bus.lsu_data  = '0;
   endtask

   task automatic apply_vec(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("v%0d", idx);
      bus.iss_valid = v.iv;
      bus.iss_rd    = v.ird;
      bus.rs1_q     = v.q1;
      bus.rs2_q     = v.q2;
      bus.alu_valid = v.av;
      bus.alu_rd    = v.ard;
      bus.alu_data  = v.ad;
      bus.lsu_valid = v.lv;
      bus.lsu_rd    = v.lrd;
      bus.lsu_data  = v.ld;
      @(negedge clk);
      chk({tag, " alu_ready"}, 32'(bus.alu_ready), 32'(v.ar));
      chk({tag, " lsu_ready"}, 32'(bus.lsu_ready), 32'(v.lr));
      chk({tag, " iss_ready"}, 32'(bus.iss_ready), 32'(v.ir));
      chk({tag, " rs1_busy"},  32'(bus.rs1_busy),  32'(v.b1));
      chk({tag, " rs2_busy"},  32'(bus.rs2_busy),  32'(v.b2));
      if (v.ar || v.lr) exp_cnt++;
      @(posedge clk);
      #1;
      chk({tag, " wEn"}, 32'(bus.wEn), 32'(v.wen));
      if (v.wen) begin
         chk({tag, " rd"}, 32'(bus.rd), 32'(v.wrd));
         chk({tag, " write_data"}, bus.write_data, v.wd);
      end
   endtask

   initial begin
      logic [AW-1:0] a_rd;
      logic [AW-1:0] l_rd;
      logic          exp_alu[4];

      n_checks = 0;
      n_errs   = 0;
      exp_cnt  = 0;
      idle_inputs();

      //          iv ird q1 q2  av ard ad             lv lrd ld             ar lr ir b1 b2 wen wrd wd
      tbl[0]  = '{0, 0,  0, 0,  0, 0,  0,             0, 0,  0,             0, 0, 1, 0, 0, 0,  0,  0};
      tbl[1]  = '{0, 0,  5, 0,  1, 5,  32'h55555555,  0, 0,  0,             1, 0, 1, 0, 0, 1,  5,  32'h55555555};
      tbl[2]  = '{0, 0,  0, 0,  0, 0,  0,             0, 0,  0,             0, 0, 1, 0, 0, 0,  0,  0};
      tbl[3]  = '{1, 7,  7, 0,  0, 0,  0,             0, 0,  0,             0, 0, 1, 0, 0, 0,  0,  0};
      tbl[4]  = '{1, 7,  7, 7,  0, 0,  0,             0, 0,  0,             0, 0, 0, 1, 1, 0,  0,  0};
      tbl[5]  = '{0, 7,  7, 0,  0, 0,  0,             1, 7,  32'h77777777,  0, 1, 1, 0, 0, 1,  7,  32'h77777777};
      tbl[6]  = '{0, 7,  7, 0,  0, 0,  0,             0, 0,  0,             0, 0, 1, 0, 0, 0,  0,  0};
      tbl[7]  = '{1, 9,  9, 0,  0, 0,  0,             0, 0,  0,             0, 0, 1, 0, 0, 0,  0,  0};
      tbl[8]  = '{1, 9,  9, 0,  1, 9,  32'h99999999,  0, 0,  0,             1, 0, 1, 0, 0, 1,  9,  32'h99999999};
      tbl[9]  = '{0, 9,  9, 7,  0, 0,  0,             0, 0,  0,             0, 0, 0, 1, 0, 0,  0,  0};
      tbl[10] = '{1, 0,  0, 0,  0, 0,  0,             1, 0,  32'hDEADBEEF,  0, 1, 1, 0, 0, 0,  0,  0};
      tbl[11] = '{0, 0,  0, 0,  0, 0,  0,             0, 0,  0,             0, 0, 1, 0, 0, 0,  0,  0};

      // Clock/reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset wEn", 32'(bus.wEn), 32'd0);
      chk("reset rd", 32'(bus.rd), 32'd0);
      chk("reset write_data", bus.write_data, 32'd0);
      chk("reset grant_cnt", 32'(bus.grant_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Tie sequence: both requesters always valid, each re-presents until accepted
`ifdef WB_ARB_FIXED_PRIO_EN
      exp_alu = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_alu = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
      a_rd = 5'd1;
      l_rd = 5'd2;
      for (int k = 0; k < 4; k++) begin
         bus.alu_valid = 1'b1;
         bus.alu_rd    = a_rd;
         bus.alu_data  = 32'hA0000000 | {27'h0, a_rd};
         bus.lsu_valid = 1'b1;
         bus.lsu_rd    = l_rd;
         bus.lsu_data  = 32'hB0000000 | {27'h0, l_rd};
         @(negedge clk);
         chk($sformatf("tie%0d alu_ready", k), 32'(bus.alu_ready), 32'(exp_alu[k]));
         chk($sformatf("tie%0d lsu_ready", k), 32'(bus.lsu_ready), 32'(!exp_alu[k]));
         exp_cnt++;
         @(posedge clk);
         #1;
         chk($sformatf("tie%0d wEn", k), 32'(bus.wEn), 32'd1);
         if (exp_alu[k]) begin
            chk($sformatf("tie%0d rd", k), 32'(bus.rd), 32'(a_rd));
            chk($sformatf("tie%0d data", k), bus.write_data, 32'hA0000000 | {27'h0, a_rd});
            a_rd = a_rd + 5'd2;
         end else begin
            chk($sformatf("tie%0d rd", k), 32'(bus.rd), 32'(l_rd));
            chk($sformatf("tie%0d data", k), bus.write_data, 32'hB0000000 | {27'h0, l_rd});
            l_rd = l_rd + 5'd2;
         end
      end
      idle_inputs();

      // Vector table
      for (int i = 0; i < 12; i++)
         apply_vec(i, tbl[i]);
      chk("grant_cnt after table", 32'(bus.grant_cnt), 32'(exp_cnt));

      // Reset with a write in flight and register 9 still pending
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd12;
      bus.alu_data  = 32'hC0C0C0C0;
      @(posedge clk);
      #1;
      idle_inputs();
      chk("inflight wEn", 32'(bus.wEn), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset wEn", 32'(bus.wEn), 32'd0);
      chk("midreset grant_cnt", 32'(bus.grant_cnt), 32'd0);
      for (int r = 0; r < NREG; r++) begin
         bus.rs1_q = AW'(r);
         #0.1;
         chk($sformatf("midreset rs1_busy[%0d]", r), 32'(bus.rs1_busy), 32'd0);
      end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First tie after reset
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd13;
      bus.alu_data  = 32'h13131313;
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 5'd14;
      bus.lsu_data  = 32'h14141414;
      @(negedge clk);
`ifdef WB_ARB_FIXED_PRIO_EN
      chk("post-reset tie lsu_ready", 32'(bus.lsu_ready), 32'd1);
`else
      chk("post-reset tie alu_ready", 32'(bus.alu_ready), 32'd1);
`endif
      @(posedge clk);
      #1;
      idle_inputs();
`ifdef WB_ARB_FIXED_PRIO_EN
      chk("post-reset tie rd", 32'(bus.rd), 32'd14);
`else
      chk("post-reset tie rd", 32'(bus.rd), 32'd13);
`endif
      chk("post-reset grant_cnt", 32'(bus.grant_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
